// File: rtl/lsu_align_pkg.sv
// lsu_align_pkg: size encodings, exception causes, FSM states and lane helpers shared by the LSU align slice.
package lsu_align_pkg;

    localparam int LSU_ADDR_W = 32;

    localparam logic [1:0] lsu_size_byte = 2'd0;
    localparam logic [1:0] lsu_size_half = 2'd1;
    localparam logic [1:0] lsu_size_word = 2'd2;

    localparam logic [3:0] except_load_addr_misalign  = 4'd4;
    localparam logic [3:0] except_store_addr_misalign = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_DONE
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] addr;
        logic                  store;
        logic [1:0]            size;
        logic                  is_unsigned;
        logic [31:0]           wdata;
    } lsu_align_in_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        error;
        logic [3:0]  ecause;
    } lsu_align_out_type;

    typedef struct packed {
        logic                  valid;
        logic [LSU_ADDR_W-1:0] addr;
        logic                  store;
        logic [3:0]            strb;
        logic [31:0]           wdata;
    } mem_req_type;

    // Size 3 is reserved and falls through to the word mask.
    function automatic logic [3:0] lsu_mask(input logic [1:0] size);
        return size == lsu_size_byte ? 4'h1 : size == lsu_size_half ? 4'h3 : 4'hF;
    endfunction

    function automatic logic lsu_split(input logic [1:0] off, input logic [1:0] size);
        return (size == lsu_size_half && off == 2'd3) || (size[1] && off != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane steering for stores and merge/extension of load words.
module lsu_lane
    import lsu_align_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] hi_i,
    output logic        split_o,
    output logic [3:0]  strb0_o,
    output logic [3:0]  strb1_o,
    output logic [31:0] wdata0_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] rdata_o
);

    logic [31:0] raw;
    logic        sx;

    assign split_o = lsu_split(off_i, size_i);
    // Shifting into a double-width lane gives first access in the low half, second in the high half.
    assign {strb1_o, strb0_o}   = {4'h0, lsu_mask(size_i)} << off_i;
    assign {wdata1_o, wdata0_o} = {32'h0, wdata_i} << {off_i, 3'b000};
    assign raw = 32'({split_o ? hi_i : 32'h0, lo_i} >> {off_i, 3'b000});
    assign sx  = ~is_unsigned_i;
    assign rdata_o = size_i == lsu_size_byte ? {{24{sx & raw[7]}}, raw[7:0]} :
                     size_i == lsu_size_half ? {{16{sx & raw[15]}}, raw[15:0]} : raw;

endmodule

// File: rtl/lsu_align.sv
// lsu_align: load/store sequencer issuing aligned word accesses, splitting misaligned ones.
// Define LSU_ALIGN_MISALIGN_SPLIT_EN to split; otherwise misaligned requests raise an exception.
module lsu_align
    import lsu_align_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic [3:0]        rsp_ecause,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_store,
    output logic [3:0]        mem_strb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_align_in_type  req_in, req_q, req_d;
    logic [31:0]       lo_q, lo_d, hi_q, hi_d;
    logic              err_q, err_d;
    logic              split;
    logic [3:0]        strb0, strb1;
    logic [31:0]       wdata0, wdata1, rdata;
    logic [ADDR_W-1:0] base;
    mem_req_type       mem_o;
    lsu_align_out_type rsp_o;

    assign req_in = '{addr: req_addr, store: req_store, size: req_size,
                      is_unsigned: req_unsigned, wdata: req_wdata};
    assign base   = {req_q.addr[ADDR_W-1:2], 2'b00};

    lsu_lane u_lane (
        .off_i         (req_q.addr[1:0]),
        .size_i        (req_q.size),
        .is_unsigned_i (req_q.is_unsigned),
        .wdata_i       (req_q.wdata),
        .lo_i          (lo_q),
        .hi_i          (hi_q),
        .split_o       (split),
        .strb0_o       (strb0),
        .strb1_o       (strb1),
        .wdata0_o      (wdata0),
        .wdata1_o      (wdata1),
        .rdata_o       (rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                req_d   = req_in;
                err_d   = 1'b0;
                state_d = S_REQ0;
`ifndef LSU_ALIGN_MISALIGN_SPLIT_EN
                if (lsu_split(req_addr[1:0], req_size)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_REQ0:  state_d = mem_ready ? S_WAIT0 : S_REQ0;
            S_WAIT0: if (mem_rvalid) begin
                lo_d    = mem_rdata;
                state_d = split ? S_REQ1 : S_DONE;
            end
            S_REQ1:  state_d = mem_ready ? S_WAIT1 : S_REQ1;
            S_WAIT1: if (mem_rvalid) begin
                hi_d    = mem_rdata;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory and response outputs are decoded from state so they read zero outside their phases.
    always_comb begin
        mem_o.valid  = state_q == S_REQ0 || state_q == S_REQ1;
        mem_o.store  = mem_o.valid & req_q.store;
        mem_o.addr   = state_q == S_REQ0 ? base : state_q == S_REQ1 ? base + ADDR_W'(4) : '0;
        mem_o.strb   = state_q == S_REQ0 ? strb0 : state_q == S_REQ1 ? strb1 : 4'h0;
        mem_o.wdata  = state_q == S_REQ0 ? wdata0 : state_q == S_REQ1 ? wdata1 : 32'h0;
        rsp_o.valid  = state_q == S_DONE;
        rsp_o.error  = rsp_o.valid & err_q;
        rsp_o.ecause = rsp_o.error ? (req_q.store ? except_store_addr_misalign : except_load_addr_misalign) : 4'h0;
        rsp_o.rdata  = rsp_o.valid && !req_q.store && !err_q ? rdata : 32'h0;
    end

    assign req_ready  = state_q == S_IDLE;
    assign mem_valid  = mem_o.valid;
    assign mem_addr   = mem_o.addr;
    assign mem_store  = mem_o.store;
    assign mem_strb   = mem_o.strb;
    assign mem_wdata  = mem_o.wdata;
    assign rsp_valid  = rsp_o.valid;
    assign rsp_rdata  = rsp_o.rdata;
    assign rsp_error  = rsp_o.error;
    assign rsp_ecause = rsp_o.ecause;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed bench for lsu_align with a one-cycle memory responder.
module tb_lsu_align;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_ready, req_store, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_ecause;
    logic        mem_valid, mem_ready, mem_store, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_word [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata [64];
    logic [3:0]  log_strb [64];
    logic        log_store [64];
    int          n_acc = 0;
    int          n_vcyc = 0;
    logic        m_acc;
    int          m_idx;

    int          lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [3:0]  r_cause;

    lsu_align dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_ecause(rsp_ecause),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_store(mem_store), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory: logs each accepted request and answers the following cycle.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clock);
            if (mem_valid) n_vcyc++;
            m_acc = mem_valid && mem_ready && !reset;
            if (m_acc) begin
                m_idx = n_acc % 64;
                log_addr[m_idx]  = mem_addr;
                log_strb[m_idx]  = mem_strb;
                log_wdata[m_idx] = mem_wdata;
                log_store[m_idx] = mem_store;
                n_acc++;
            end
            @(posedge clock);
            #1;
            mem_rvalid = m_acc;
            mem_rdata  = m_acc ? rd_word[m_idx] : 32'h0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic st, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd);
        @(posedge clock);
        #1;
        req_valid = 1'b1; req_addr = a; req_store = st; req_size = sz;
        req_unsigned = u; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                lat = i; r_rdata = rsp_rdata; r_err = rsp_error; r_cause = rsp_ecause;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = 0; req_store = 0; req_size = 0;
        req_unsigned = 0; req_wdata = 0; mem_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({req_ready, mem_valid, mem_store, mem_strb, rsp_valid, rsp_error, rsp_ecause} !== 13'b1_0_0_0000_0_0_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b mv=%b ms=%b strb=%h rv=%b err=%b cause=%h want rdy=1 rest 0",
                     req_ready, mem_valid, mem_store, mem_strb, rsp_valid, rsp_error, rsp_ecause);
        end
        checks++;
        if ({mem_addr, mem_wdata, rsp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want all 0", mem_addr, mem_wdata, rsp_rdata);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_aligned_lw();
        int b = n_acc;
        rd_word[b % 64] = 32'hDEADBEEF;
        issue(32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        checks++;
        if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL lw_rdata: got %h err=%b want deadbeef err=0", r_rdata, r_err);
        end
        checks++;
        if (n_acc - b !== 1 || log_addr[b % 64] !== 32'h1000 || log_strb[b % 64] !== 4'hF || log_store[b % 64] !== 1'b0) begin
            errors++;
            $display("FAIL lw_access: got n=%0d addr=%h strb=%h st=%b want n=1 addr=00001000 strb=f st=0",
                     n_acc - b, log_addr[b % 64], log_strb[b % 64], log_store[b % 64]);
        end
        @(negedge clock);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL lw_pulse: got rv=%b rdy=%b want rv=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_sub_word();
        int b = n_acc;
        rd_word[b % 64] = 32'h80000000;
        rd_word[(b + 1) % 64] = 32'h80000000;
        rd_word[(b + 2) % 64] = 32'h80017777;
        rd_word[(b + 3) % 64] = 32'h80017777;
        rd_word[(b + 4) % 64] = 32'h7F00FF01;
        issue(32'h2003, 1'b0, 2'd0, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (r_rdata !== 32'hFFFFFF80 || log_strb[b % 64] !== 4'h8 || log_addr[b % 64] !== 32'h2000) begin
            errors++; $display("FAIL lb: got rdata=%h strb=%h addr=%h want ffffff80 8 00002000",
                               r_rdata, log_strb[b % 64], log_addr[b % 64]);
        end
        issue(32'h2003, 1'b0, 2'd0, 1'b1, 32'h0);
        wait_rsp();
        checks++;
        if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", r_rdata); end
        issue(32'h1002, 1'b0, 2'd1, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (r_rdata !== 32'hFFFF8001 || log_strb[(b + 2) % 64] !== 4'hC || lat !== 3) begin
            errors++; $display("FAIL lh: got rdata=%h strb=%h lat=%0d want ffff8001 c 3",
                               r_rdata, log_strb[(b + 2) % 64], lat);
        end
        issue(32'h1002, 1'b0, 2'd1, 1'b1, 32'h0);
        wait_rsp();
        checks++;
        if (r_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h want 00008001", r_rdata); end
        issue(32'h3000, 1'b0, 2'd3, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (r_rdata !== 32'h7F00FF01 || log_strb[(b + 4) % 64] !== 4'hF) begin
            errors++; $display("FAIL size3: got rdata=%h strb=%h want 7f00ff01 f", r_rdata, log_strb[(b + 4) % 64]);
        end
    endtask

    task automatic test_stores();
        int b = n_acc;
        issue(32'h1001, 1'b1, 2'd1, 1'b0, 32'h1234BEEF);
        wait_rsp();
        checks++;
        if (log_addr[b % 64] !== 32'h1000 || log_strb[b % 64] !== 4'h6 || log_wdata[b % 64] !== 32'h34BEEF00 || log_store[b % 64] !== 1'b1) begin
            errors++; $display("FAIL sh_lane: got addr=%h strb=%h wdata=%h st=%b want 00001000 6 34beef00 1",
                               log_addr[b % 64], log_strb[b % 64], log_wdata[b % 64], log_store[b % 64]);
        end
        checks++;
        if (r_rdata !== 32'h0 || r_err !== 1'b0 || lat !== 3) begin
            errors++; $display("FAIL sh_rsp: got rdata=%h err=%b lat=%0d want 0 0 3", r_rdata, r_err, lat);
        end
        issue(32'h1002, 1'b1, 2'd0, 1'b0, 32'hFFFFFFA5);
        wait_rsp();
        checks++;
        if (log_strb[(b + 1) % 64] !== 4'h4 || log_wdata[(b + 1) % 64] !== 32'hFFA50000) begin
            errors++; $display("FAIL sb_lane: got strb=%h wdata=%h want 4 ffa50000",
                               log_strb[(b + 1) % 64], log_wdata[(b + 1) % 64]);
        end
    endtask

    task automatic test_ready_stall();
        int b = n_acc;
        mem_ready = 1'b0;
        issue(32'h4000, 1'b1, 2'd2, 1'b0, 32'h11223344);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h4000 || mem_strb !== 4'hF || mem_wdata !== 32'h11223344 || req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got mv=%b addr=%h strb=%h wdata=%h rdy=%b want 1 00004000 f 11223344 0",
                                   i, mem_valid, mem_addr, mem_strb, mem_wdata, req_ready);
            end
        end
        @(posedge clock);
        #1;
        mem_ready = 1'b1;
        wait_rsp();
        checks++;
        if (lat !== 3 || n_acc - b !== 1 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL stall_done: got lat=%0d n=%0d rdata=%h want 3 1 0", lat, n_acc - b, r_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
`ifdef LSU_ALIGN_MISALIGN_SPLIT_EN
        issue(32'h5001, 1'b0, 2'd2, 1'b0, 32'h0);
        repeat (3) begin @(posedge clock); #1; end
`else
        issue(32'h5000, 1'b0, 2'd2, 1'b0, 32'h0);
        @(posedge clock);
        #1;
`endif
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_idle: got rdy=%b rv=%b mv=%b want 1 0 0", req_ready, rsp_valid, mem_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_rsp: got %0d rsp pulses want 0", seen); end
    endtask

`ifdef LSU_ALIGN_MISALIGN_SPLIT_EN
    task automatic test_split();
        int b = n_acc;
        rd_word[b % 64] = 32'hAABBCCDD;
        rd_word[(b + 1) % 64] = 32'h11223344;
        issue(32'h1003, 1'b0, 2'd2, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (lat !== 5 || r_rdata !== 32'h223344AA || r_err !== 1'b0) begin
            errors++; $display("FAIL split_lw_rsp: got lat=%0d rdata=%h err=%b want 5 223344aa 0", lat, r_rdata, r_err);
        end
        checks++;
        if (log_addr[b % 64] !== 32'h1000 || log_strb[b % 64] !== 4'h8 || log_addr[(b + 1) % 64] !== 32'h1004 || log_strb[(b + 1) % 64] !== 4'h7) begin
            errors++; $display("FAIL split_lw_acc: got %h/%h %h/%h want 00001000/8 00001004/7",
                               log_addr[b % 64], log_strb[b % 64], log_addr[(b + 1) % 64], log_strb[(b + 1) % 64]);
        end
        issue(32'hFFFFFFFF, 1'b1, 2'd1, 1'b0, 32'h0000BEEF);
        wait_rsp();
        checks++;
        if (log_addr[(b + 2) % 64] !== 32'hFFFFFFFC || log_strb[(b + 2) % 64] !== 4'h8 || log_wdata[(b + 2) % 64] !== 32'hEF000000) begin
            errors++; $display("FAIL split_sh_first: got %h %h %h want fffffffc 8 ef000000",
                               log_addr[(b + 2) % 64], log_strb[(b + 2) % 64], log_wdata[(b + 2) % 64]);
        end
        checks++;
        if (log_addr[(b + 3) % 64] !== 32'h0 || log_strb[(b + 3) % 64] !== 4'h1 || log_wdata[(b + 3) % 64] !== 32'h000000BE) begin
            errors++; $display("FAIL split_sh_second: got %h %h %h want 00000000 1 000000be",
                               log_addr[(b + 3) % 64], log_strb[(b + 3) % 64], log_wdata[(b + 3) % 64]);
        end
    endtask
`else
    task automatic test_misalign();
        int b = n_acc;
        int v = n_vcyc;
        issue(32'h1002, 1'b1, 2'd2, 1'b0, 32'h12345678);
        wait_rsp();
        checks++;
        if (lat !== 1 || r_err !== 1'b1 || r_cause !== 4'd6 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL sw_misalign: got lat=%0d err=%b cause=%0d rdata=%h want 1 1 6 0", lat, r_err, r_cause, r_rdata);
        end
        issue(32'h1003, 1'b0, 2'd2, 1'b0, 32'h0);
        wait_rsp();
        checks++;
        if (r_err !== 1'b1 || r_cause !== 4'd4 || r_rdata !== 32'h0) begin
            errors++; $display("FAIL lw_misalign: got err=%b cause=%0d rdata=%h want 1 4 0", r_err, r_cause, r_rdata);
        end
        issue(32'h1003, 1'b0, 2'd1, 1'b1, 32'h0);
        wait_rsp();
        checks++;
        if (r_err !== 1'b1 || r_cause !== 4'd4) begin
            errors++; $display("FAIL lhu_misalign: got err=%b cause=%0d want 1 4", r_err, r_cause);
        end
        checks++;
        if (n_acc !== b || n_vcyc !== v) begin
            errors++; $display("FAIL misalign_nomem: got %0d accesses %0d valid cycles want 0 0", n_acc - b, n_vcyc - v);
        end
        @(negedge clock);
        checks++;
        if (rsp_error !== 1'b0 || rsp_ecause !== 4'h0) begin
            errors++; $display("FAIL misalign_clear: got err=%b cause=%0d want 0 0", rsp_error, rsp_ecause);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_aligned_lw();
        test_sub_word();
        test_stores();
        test_ready_stall();
        test_reset_mid();
`ifdef LSU_ALIGN_MISALIGN_SPLIT_EN
        test_split();
`else
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
